// File: rtl/patch_matcher.sv
// Burst-address patch engine: a config-written slot table is matched against
// each burst start address, and a hit streams words out of a content RAM.
module patch_matcher #(
  parameter int N_PATCHES  = 16,
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 16,
  parameter int CONTENT_AW = 13
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic [15:0]       config_addr,
  input  logic [15:0]       config_data,
  input  logic              config_strobe,
  input  logic [ADDR_W-1:0] burst_addr,
  input  logic              burst_addr_strobe,
  input  logic              patch_data_next,
  output logic              patch_trigger,
  output logic              patch_active,
  output logic [7:0]        patch_index,
  output logic [DATA_W-1:0] patch_data
);
  localparam int SW     = (N_PATCHES > 1) ? $clog2(N_PATCHES) : 1;
  localparam int CAW    = CONTENT_AW;
  localparam int STAGES = 2;

  logic [N_PATCHES-1:0][ADDR_W-1:0] r_val, r_mask;
  logic [N_PATCHES-1:0][CAW-1:0]    r_off;
  logic [N_PATCHES-1:0][15:0]       r_len;
  logic [N_PATCHES-1:0]             r_en;

  logic [8:0]    w_slot;
  logic [SW-1:0] w_sidx;
  logic          w_tbl_we, w_mem_we, w_unused_cfg;

  // Slot field sits in addr[11:3]; bit 11 set always means slot >= 256.
  assign w_slot       = config_addr[11:3];
  assign w_sidx       = w_slot[SW-1:0];
  assign w_tbl_we     = config_strobe && (config_addr[15:12] == 4'h7) &&
                        ({23'd0, w_slot} < N_PATCHES);
  assign w_mem_we     = config_strobe && config_addr[15];
  assign w_unused_cfg = ^config_addr;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_val  <= '0;
      r_mask <= '0;
      r_off  <= '0;
      r_len  <= '0;
      r_en   <= '0;
    end else if (w_tbl_we) begin
      case (config_addr[2:0])
        3'd0:    r_val[w_sidx][15:0]         <= config_data;
        3'd1:    r_val[w_sidx][ADDR_W-1:16]  <= config_data[ADDR_W-17:0];
        3'd2:    r_mask[w_sidx][15:0]        <= config_data;
        3'd3:    r_mask[w_sidx][ADDR_W-1:16] <= config_data[ADDR_W-17:0];
        3'd4:    r_off[w_sidx]               <= config_data[CAW-1:0];
        3'd5:    r_len[w_sidx]               <= config_data;
        3'd6:    r_en[w_sidx]                <= config_data[0];
        default: ;
      endcase
    end
  end

  // Content RAM: not reset, registered read port.
  logic [DATA_W-1:0] r_mem [2**CAW];
  logic [DATA_W-1:0] r_mem_q;
  logic [CAW-1:0]    r_rd_addr;

  always_ff @(posedge mclk) begin
    if (w_mem_we) r_mem[config_addr[CAW-1:0]] <= config_data[DATA_W-1:0];
    r_mem_q <= r_mem[r_rd_addr];
  end

  logic [STAGES:0]       r_vld_pipe;
  logic [ADDR_W-1:0]     r_addr1;
  logic [CAW-1:0]        r_addr2, r_addr3;
  logic [N_PATCHES-1:0]  r_mvec, w_match;
  logic [SW-1:0]         r_idx, w_first;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_PATCHES; i++)
      w_match[i] = r_en[i] && (((r_addr1 ^ r_val[i]) & ~r_mask[i]) == '0);
  end

  always_comb begin
    w_first = '0;
    for (int i = N_PATCHES-1; i >= 0; i--)
      if (r_mvec[i]) w_first = SW'(i);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe    <= '0;
      r_addr1       <= '0;
      r_addr2       <= '0;
      r_addr3       <= '0;
      r_mvec        <= '0;
      r_idx         <= '0;
      patch_trigger <= 1'b0;
    end else begin
      r_vld_pipe    <= {r_vld_pipe[STAGES-1:0], burst_addr_strobe};
      if (burst_addr_strobe) r_addr1 <= burst_addr;
      r_mvec        <= w_match;
      r_addr2       <= r_addr1[CAW-1:0];
      r_addr3       <= r_addr2;
      patch_trigger <= r_vld_pipe[1] && (|r_mvec);
      if (r_vld_pipe[1] && (|r_mvec)) r_idx <= w_first;
    end
  end

  assign patch_index = 8'(r_idx);

  // A zero count while active means an unlimited-length patch.
  logic [15:0] r_cnt;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr    <= '0;
      r_cnt        <= '0;
      patch_active <= 1'b0;
      patch_data   <= '0;
    end else begin
      patch_data <= r_mem_q;
      if (r_vld_pipe[STAGES]) begin
        if (patch_trigger) begin
          r_rd_addr    <= r_off[r_idx] + r_addr3;
          r_cnt        <= r_len[r_idx];
          patch_active <= 1'b1;
        end else begin
          patch_active <= 1'b0;
        end
      end else if (patch_data_next && patch_active) begin
        r_rd_addr <= r_rd_addr + CAW'(1);
        if (r_cnt != 16'd0) begin
          r_cnt <= r_cnt - 16'd1;
          if (r_cnt == 16'd1) patch_active <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_patch_matcher.sv
// Directed and randomized checks of patch_matcher against a slot-table model.
module tb_patch_matcher;
  localparam int N = 16, AW = 23, DW = 16, CAW = 13, CSZ = 1 << CAW;

  logic          mclk = 1'b0, reset_n = 1'b0;
  logic [15:0]   config_addr = '0, config_data = '0;
  logic          config_strobe = 1'b0;
  logic [AW-1:0] burst_addr = '0;
  logic          burst_addr_strobe = 1'b0, patch_data_next = 1'b0;
  logic          patch_trigger, patch_active;
  logic [7:0]    patch_index;
  logic [DW-1:0] patch_data;

  patch_matcher #(.N_PATCHES(N), .ADDR_W(AW), .DATA_W(DW), .CONTENT_AW(CAW)) dut (
    .mclk(mclk), .reset_n(reset_n), .config_addr(config_addr), .config_data(config_data),
    .config_strobe(config_strobe), .burst_addr(burst_addr),
    .burst_addr_strobe(burst_addr_strobe), .patch_data_next(patch_data_next),
    .patch_trigger(patch_trigger), .patch_active(patch_active),
    .patch_index(patch_index), .patch_data(patch_data)
  );

  always #5 mclk = ~mclk;

  int unsigned m_val[N], m_mask[N], m_off[N], m_len[N];
  bit          m_en[N];
  int unsigned m_mem[CSZ];
  int unsigned m_addr, m_cnt, m_idx;
  bit          m_act;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i] = 0; m_mask[i] = 0; m_off[i] = 0; m_len[i] = 0; m_en[i] = 0;
    end
    m_addr = 0; m_cnt = 0; m_idx = 0; m_act = 0;
  endtask

  // Called at a negedge; returns at the next negedge with the write applied.
  task automatic cfg(input int unsigned a, input int unsigned d);
    int unsigned s, k;
    config_addr = a[15:0]; config_data = d[15:0]; config_strobe = 1'b1;
    @(negedge mclk);
    config_strobe = 1'b0;
    d = d & 32'hFFFF;
    if (a >= 32'h8000) m_mem[(a - 32'h8000) % CSZ] = d;
    else if (a >= 32'h7000) begin
      s = (a - 32'h7000) / 8; k = a % 8;
      if (s < N) case (k)
        0: m_val[s]  = ((m_val[s]  & 32'hFFFF_0000) | d) % (1 << AW);
        1: m_val[s]  = ((m_val[s]  & 32'h0000_FFFF) | (d << 16)) % (1 << AW);
        2: m_mask[s] = ((m_mask[s] & 32'hFFFF_0000) | d) % (1 << AW);
        3: m_mask[s] = ((m_mask[s] & 32'h0000_FFFF) | (d << 16)) % (1 << AW);
        4: m_off[s]  = d % CSZ;
        5: m_len[s]  = d;
        6: m_en[s]   = d[0];
        default: ;
      endcase
    end
  endtask

  task automatic set_slot(input int s, input int unsigned v, input int unsigned m,
                          input int unsigned off, input int unsigned len, input bit en);
    int unsigned b;
    b = 32'h7000 + 8 * s;
    cfg(b + 0, v & 32'hFFFF); cfg(b + 1, v >> 16);
    cfg(b + 2, m & 32'hFFFF); cfg(b + 3, m >> 16);
    cfg(b + 4, off); cfg(b + 5, len); cfg(b + 6, 32'(en));
  endtask

  function automatic int lookup(input int unsigned a);
    for (int i = 0; i < N; i++)
      if (m_en[i] && (((a ^ m_val[i]) & ~m_mask[i]) == 0)) return i;
    return -1;
  endfunction

  function automatic void model_hit(input int h, input int unsigned a);
    m_idx = h; m_act = 1;
    m_addr = (m_off[h] + (a % CSZ)) % CSZ;
    m_cnt = m_len[h];
  endfunction

  // Isolated lookup: strobe, walk to T+6, check trigger/index/active/data.
  task automatic lookup_txn(input int unsigned a);
    int h;
    h = lookup(a);
    burst_addr = AW'(a); burst_addr_strobe = 1'b1;
    @(negedge mclk); burst_addr_strobe = 1'b0;
    chk("trig_t1", 32'(patch_trigger), 0);
    @(negedge mclk);
    chk("trig_t2", 32'(patch_trigger), 0);
    @(negedge mclk);
    chk("trig_t3", 32'(patch_trigger), 32'(h >= 0));
    if (h >= 0) model_hit(h, a); else m_act = 0;
    chk("index_t3", 32'(patch_index), m_idx);
    @(negedge mclk);
    chk("trig_t4", 32'(patch_trigger), 0);
    chk("active_t4", 32'(patch_active), 32'(m_act));
    @(negedge mclk); @(negedge mclk);
    chk("data_t6", 32'(patch_data), m_mem[m_addr]);
  endtask

  task automatic nxt();
    patch_data_next = 1'b1;
    @(negedge mclk); patch_data_next = 1'b0;
    if (m_act) begin
      m_addr = (m_addr + 1) % CSZ;
      if (m_cnt != 0) begin m_cnt--; if (m_cnt == 0) m_act = 0; end
    end
    chk("active_next", 32'(patch_active), 32'(m_act));
    @(negedge mclk); @(negedge mclk);
    chk("data_next", 32'(patch_data), m_mem[m_addr]);
  endtask

  initial begin
    int unsigned st, a, v, m;
    int s;
    model_reset();
    repeat (3) @(negedge mclk);
    chk("rst_trig", 32'(patch_trigger), 0);
    chk("rst_active", 32'(patch_active), 0);
    chk("rst_index", 32'(patch_index), 0);
    chk("rst_data", 32'(patch_data), 0);
    reset_n = 1'b1;
    @(negedge mclk);
    for (int i = 0; i < CSZ; i++) cfg(32'h8000 + i, $urandom);

    // Slot 2 patch of three words
    set_slot(2, 32'h001000, 32'h0000FF, 32'h100, 3, 1);
    st = (32'h100 + 32'h1010) % CSZ;
    cfg(32'h8000 + st, 32'hA); cfg(32'h8000 + st + 1, 32'hB); cfg(32'h8000 + st + 2, 32'hC);
    lookup_txn(32'h001010);
    chk("s2_index", 32'(patch_index), 2);
    chk("s2_word0", 32'(patch_data), 32'hA);
    nxt(); chk("s2_word1", 32'(patch_data), 32'hB);
    nxt(); chk("s2_word2", 32'(patch_data), 32'hC);
    nxt(); chk("s2_done", 32'(patch_active), 0);
    nxt(); // ignored while inactive

    // Lowest slot wins
    set_slot(1, 32'h400000, 32'h0, 32'h20, 5, 1);
    set_slot(5, 32'h400000, 32'hFF, 32'h40, 7, 1);
    lookup_txn(32'h400000);
    chk("prio_index", 32'(patch_index), 1);

    // Disabled slot and ignored writes
    lookup_txn(32'h7FFFFF);
    set_slot(7, 32'h123456, 32'h0, 32'h5, 2, 1);
    cfg(32'h7000 + 8 * 7 + 6, 0);
    cfg(32'h7000 + 8 * 7 + 7, 32'hFFFF);
    cfg(32'h7000 + 8 * N + 6, 1);
    cfg(32'h6000 + 8 * 7 + 6, 1);
    lookup_txn(32'h123456);
    chk("dis_active", 32'(patch_active), 0);
    lookup_txn(32'h000000);

    // Address wrap with unlimited length
    set_slot(3, 32'h000001, 32'h0, 32'h1FFF, 0, 1);
    lookup_txn(32'h000001);
    chk("wrap_start", m_addr, 0);
    repeat (10) nxt();
    chk("wrap_active", 32'(patch_active), 1);
    chk("wrap_data", 32'(patch_data), m_mem[32'hA]);

    // Hit then miss two cycles later
    burst_addr = AW'(32'h001010); burst_addr_strobe = 1'b1;
    @(negedge mclk); burst_addr_strobe = 1'b0;
    @(negedge mclk);
    burst_addr = AW'(32'h7FFFFF); burst_addr_strobe = 1'b1;
    chk("hm_trig_t2", 32'(patch_trigger), 0);
    @(negedge mclk); burst_addr_strobe = 1'b0;
    chk("hm_trig_t3", 32'(patch_trigger), 1);
    chk("hm_index", 32'(patch_index), 2);
    @(negedge mclk);
    chk("hm_act_t4", 32'(patch_active), 1);
    chk("hm_trig_t4", 32'(patch_trigger), 0);
    @(negedge mclk);
    chk("hm_trig_t5", 32'(patch_trigger), 0);
    chk("hm_act_t5", 32'(patch_active), 1);
    @(negedge mclk);
    chk("hm_act_t6", 32'(patch_active), 0);
    model_hit(2, 32'h001010); m_act = 0;
    @(negedge mclk); @(negedge mclk);
    chk("hm_data", 32'(patch_data), m_mem[m_addr]);

    // Back-to-back hits
    burst_addr = AW'(32'h400000); burst_addr_strobe = 1'b1;
    @(negedge mclk); burst_addr = AW'(32'h001010);
    @(negedge mclk); burst_addr_strobe = 1'b0;
    @(negedge mclk);
    chk("b2b_trig0", 32'(patch_trigger), 1);
    chk("b2b_idx0", 32'(patch_index), 1);
    @(negedge mclk);
    chk("b2b_trig1", 32'(patch_trigger), 1);
    chk("b2b_idx1", 32'(patch_index), 2);
    chk("b2b_act", 32'(patch_active), 1);
    @(negedge mclk);
    chk("b2b_trig2", 32'(patch_trigger), 0);
    model_hit(2, 32'h001010);
    @(negedge mclk); @(negedge mclk);
    chk("b2b_data", 32'(patch_data), m_mem[m_addr]);
    nxt();

    // Reset in the middle of a hit lookup
    burst_addr = AW'(32'h001010); burst_addr_strobe = 1'b1;
    @(negedge mclk); burst_addr_strobe = 1'b0;
    @(negedge mclk);
    reset_n = 1'b0;
    #1;
    chk("mrst_trig", 32'(patch_trigger), 0);
    chk("mrst_active", 32'(patch_active), 0);
    chk("mrst_index", 32'(patch_index), 0);
    chk("mrst_data", 32'(patch_data), 0);
    @(negedge mclk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge mclk);
      chk("mrst_no_trig", 32'(patch_trigger), 0);
    end
    lookup_txn(32'h001010);
    lookup_txn(32'h400000);

    // Randomized table and traffic
    for (int i = 0; i < N; i++)
      set_slot(i, $urandom % (1 << AW), $urandom & $urandom & $urandom % (1 << AW),
               $urandom % CSZ, $urandom_range(0, 4), ($urandom_range(0, 3) != 0));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 7) begin
        s = $urandom_range(0, N - 1);
        m = m_mask[s];
        v = m_val[s] ^ ($urandom & m);
        a = v;
      end else a = $urandom % (1 << AW);
      lookup_txn(a);
      repeat ($urandom_range(0, 5)) nxt();
      if ($urandom_range(0, 3) == 0) cfg($urandom_range(32'h7080, 32'h7FFF), $urandom);
      if ($urandom_range(0, 3) == 0) cfg($urandom_range(0, 32'h6FFF), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
